// File: rtl/fsm_sequencer_pkg.sv
// Shared types and core transition rules for the sequencer and its state machine core.
package fsm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctl_state_t;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    // Next core state for input x.
    function automatic logic [1:0] core_next(input logic [1:0] s, input logic x);
        logic [1:0] n;
        n = S00;
        case (s)
            S00:     n = x ? S11 : S01;
            S01:     n = x ? S10 : S00;
            S10:     n = x ? S01 : S10;
            default: n = x ? S10 : S11;
        endcase
        return n;
    endfunction

    // z flag of a core state: only A,B = 00 reports zero.
    function automatic logic core_z(input logic [1:0] s);
        return (s != S00);
    endfunction

endpackage

// File: rtl/fsm_sequencer_core.sv
// Embedded 2-bit serial state machine: one transition per enabled step.
module fsm_step_core
    import fsm_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       clr,
    input  logic       step,
    input  logic       x,
    output logic [1:0] state,
    output logic       z_c
);

    logic [1:0] state_d;

    // Next state: clear wins over step, otherwise hold.
    always_comb begin
        state_d = state;
        if (clr) begin
            state_d = S00;
        end else if (step) begin
            state_d = core_next(state, x);
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S00;
        end else begin
            state <= state_d;
        end
    end

    assign z_c = core_z(state);

endmodule

// File: rtl/fsm_sequencer.sv
// Host-facing sequencer: applies a loaded pattern to the core one bit per clock and captures z.
module fsm_sequencer
    import fsm_sequencer_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic [W-1:0]  pattern,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [1:0]    final_state
);

    ctl_state_t    ctl_q, ctl_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          busy_d, done_d, err_d;
    logic [W-1:0]  result_d;
    logic [1:0]    final_d;
    logic          core_clr_c, core_step_c;
    logic [1:0]    core_state;
    logic          core_z_c;
    logic          len_ok_c;

    assign len_ok_c = (len != '0) && (len <= LW'(W));

    fsm_step_core u_core (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (core_clr_c),
        .step  (core_step_c),
        .x     (shreg_q[0]),
        .state (core_state),
        .z_c   (core_z_c)
    );

    // Next-state and output decode for the controller.
    always_comb begin
        ctl_d       = ctl_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        result_d    = result;
        final_d     = final_state;
        core_clr_c  = 1'b0;
        core_step_c = 1'b0;

        case (ctl_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    if (len_ok_c) begin
                        shreg_d    = pattern;
                        cnt_d      = len;
                        idx_d      = '0;
                        result_d   = '0;
                        core_clr_c = 1'b1;
                        busy_d     = 1'b1;
                        ctl_d      = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                core_step_c = 1'b1;
                // z is taken from the core state before this step.
                for (int unsigned i = 0; i < W; i++) begin
                    if (idx_q == LW'(i)) begin
                        result_d[i] = core_z_c;
                    end
                end
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + LW'(1);
                cnt_d   = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) begin
                    final_d = core_next(core_state, shreg_q[0]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ctl_d   = DONE;
                end
            end
            DONE: begin
                busy_d = 1'b0;
                ctl_d  = IDLE;
            end
            default: begin
                busy_d = 1'b0;
                ctl_d  = IDLE;
            end
        endcase
    end

    // Controller and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctl_q       <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
            final_state <= S00;
        end else begin
            ctl_q       <= ctl_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            result      <= result_d;
            final_state <= final_d;
        end
    end

endmodule

// File: tb/tb_fsm_sequencer.sv
// Self-checking bench for fsm_sequencer against a sequence-level reference model.
module tb_fsm_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 5;

    logic          CLK     = 1'b0;
    logic          RESET   = 1'b1;
    logic          start   = 1'b0;
    logic [LW-1:0] len     = '0;
    logic [W-1:0]  pattern = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  result;
    logic [1:0]    final_state;

    always #5 CLK = ~CLK;

    fsm_sequencer #(.W(W), .LW(LW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .len         (len),
        .pattern     (pattern),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .result      (result),
        .final_state (final_state)
    );

    // Transition table of the core, indexed by state, one array per x value.
    int nxt0 [4] = '{1, 0, 2, 3};
    int nxt1 [4] = '{3, 2, 1, 2};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: busy cycles left, one-shot flags, held outputs.
    bit         m_valid = 1'b0;
    int         m_cnt   = 0;
    bit         m_done  = 1'b0;
    bit         m_err   = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [1:0]   m_fin = '0;
    logic [W-1:0] p_res = '0;
    logic [1:0]   p_fin = '0;
    int         m_acc_cyc  = 0;
    int         m_done_cyc = 0;
    bit         prev_done;
    int         s;
    logic [W-1:0] r;

    // Hand-computed expectations for directed runs.
    int           pin_seq  = 0;
    int           pin_seen = 0;
    logic [W-1:0] pin_res  = '0;
    logic [1:0]   pin_fin  = '0;
    int           pin_lat  = 0;

    // Model: whole sequence evaluated at acceptance; done follows len busy cycles.
    always @(posedge CLK) begin
        prev_done = m_done;
        cyc++;
        if (RESET) begin
            m_valid = 1'b1;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_res   = '0;
            m_fin   = '0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done     = 1'b1;
                    m_res      = p_res;
                    m_fin      = p_fin;
                    m_done_cyc = cyc;
                end
            end else if (!prev_done && start) begin
                if (int'(len) >= 1 && int'(len) <= int'(W)) begin
                    s = 0;
                    r = '0;
                    for (int i = 0; i < int'(len); i++) begin
                        r[i] = (s != 0);
                        s = pattern[i] ? nxt1[s] : nxt0[s];
                    end
                    p_res     = r;
                    p_fin     = 2'(s);
                    m_cnt     = int'(len);
                    m_acc_cyc = cyc;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            check("busy", 32'(busy), 32'(m_cnt > 0));
            check("done", 32'(done), 32'(m_done));
            check("err",  32'(err),  32'(m_err));
            if (m_cnt == 0) begin
                check("result",      32'(result),      32'(m_res));
                check("final_state", 32'(final_state), 32'(m_fin));
            end
            if (m_done && pin_seq != pin_seen) begin
                pin_seen = pin_seq;
                check("pin_result",  32'(result),                 32'(pin_res));
                check("pin_final",   32'(final_state),            32'(pin_fin));
                check("pin_latency", 32'(m_done_cyc - m_acc_cyc), 32'(pin_lat));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] p, input logic [LW-1:0] l, input int hold);
        start   = 1'b1;
        len     = l;
        pattern = p;
        idle(hold);
        start   = 1'b0;
    endtask

    // Latency here counts edges from acceptance to the edge that raises done.
    task automatic pin(input logic [W-1:0] res, input logic [1:0] fin, input int lat);
        pin_res = res;
        pin_fin = fin;
        pin_lat = lat;
        pin_seq++;
    endtask

    initial begin
        idle(2);
        RESET = 1'b0;
        idle(2);

        pin(16'h0000, 2'b11, 1);
        do_start(16'h0001, 5'd1, 1);
        idle(4);

        pin(16'h000E, 2'b01, 4);
        do_start(16'h000D, 5'd4, 1);
        idle(7);

        pin(16'h0002, 2'b01, 3);
        do_start(16'h0000, 5'd3, 1);
        idle(6);

        do_start(16'h1234, 5'd0, 1);
        idle(2);
        do_start(16'h4321, 5'd17, 1);
        idle(3);

        // Start held through RUN and DONE, then accepted again in IDLE.
        do_start(16'h00A5, 5'd4, 12);
        idle(8);

        // Reset on the fifth step of a full-length run.
        do_start(16'hFFFF, 5'd16, 1);
        idle(4);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        idle(3);

        repeat (150) begin
            if ($urandom_range(0, 19) == 0) begin
                RESET = 1'b1;
                idle(1);
                RESET = 1'b0;
            end else begin
                do_start(16'($urandom), 5'($urandom_range(0, 20)), int'($urandom_range(1, 3)));
            end
            idle(int'($urandom_range(0, 20)));
        end

        idle(25);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_sequencer.md
Name: fsm_sequencer

Overview:
- Controller that drives the team's 2-bit serial state machine (states A,B; input x; flag z) with a loaded bit pattern, one bit per clock.
- Captures the per-step z flag into a result word and reports the final state.
- Sits between a host (start/len/pattern handshake) and an embedded copy of the state machine core; lets the host run whole sequences without bit-level timing.

Parameters:
- W, 16, maximum pattern length in bits; width of pattern and result.
- LW, $clog2(W+1), width of the len port and the internal step counter.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  request to run a sequence; sampled only in IDLE.
- len  input  LW  number of bits to apply; valid range 1..W.
- pattern  input  W  x bits to apply, LSB first.
- busy  output  1  high while a sequence is running (RUN).
- done  output  1  one-cycle pulse when a sequence completes.
- err  output  1  one-cycle pulse when start is rejected for a bad len.
- result  output  W  z flags captured per step; bit i belongs to step i.
- final_state  output  2  core state {A,B} after the last step.

Behaviour:
- Reset (RESET=1 at a rising edge):
  - busy=0, done=0, err=0, result=0, final_state=2'b00.
  - Controller goes to IDLE; core state goes to 00; counter and shift register cleared.
  - Reset takes priority over everything, including mid-RUN; a sequence aborted by reset produces no done.
- Core transition table (state -> next for x=0 / x=1; z of state):
  - 00 -> 01 / 11, z=0
  - 01 -> 00 / 10, z=1
  - 10 -> 10 / 01, z=1
  - 11 -> 11 / 10, z=1
- Controller states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with 1<=len<=W: load shift register with pattern, counter=len, step index=0, core state=00, clear result. Next state RUN.
  - start=1 with len=0 or len>W: err=1 for the next cycle only; stay in IDLE; result and final_state unchanged.
- RUN (busy=1), at each rising edge:
  - x is the shift register LSB.
  - result[index] gets z of the current core state, taken before the step.
  - Core steps per the table; shift register shifts right; index increments; counter decrements.
  - On the edge where the counter goes 1->0: latch final_state with the post-step core state and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
  - A start present during DONE is ignored; it is sampled again in IDLE.
- Outputs held: result and final_state stay stable from DONE until the next accepted start clears result.
- Result bits at index >= len are 0.
- start while busy (RUN) is ignored; there is no queueing.
- Latency: start accepted at edge T -> busy high cycles T+1..T+len -> done high in cycle T+len+1. Back-to-back throughput is len+2 cycles per sequence.
- Arithmetic: counter and index are LW bits wide and cannot overflow because len<=W. No wrap-around beyond W steps.

Decomposition:
- Shared package:
  - controller state enum (IDLE, RUN, DONE);
  - 2-bit core state constants S00..S11;
  - a function giving next state from (state, x);
  - a function giving z of a state.
- One sub-module, fsm_step_core:
  - holds the 2-bit core state with synchronous active-high reset, a synchronous clear, and a step enable;
  - outputs state and z.
- The controller instantiates it once.

Test Plan:
- RESET asserted mid-RUN (pattern=0xFFFF, len=16, reset at step 5) -> next cycle busy=0, done never pulses, result=0, final_state=00, IDLE.
- pattern=0x0001, len=1 -> busy one cycle, done at T+2, result=0x0000, final_state=2'b11.
- pattern=0x000D, len=4 (x=1,0,1,1) -> states 00->11->11->10->01, result=0x000E, final_state=2'b01, done at T+5.
- pattern=0x0000, len=3 -> states 00->01->00->01, result=0x0002, final_state=2'b01.
- start with len=0, then with len=17 -> err pulses one cycle each, busy stays 0, prior result/final_state unchanged.
- start re-asserted during RUN and during DONE of a len=4 run -> ignored; a start held into IDLE is accepted; exactly one done per accepted start.
